// File: rtl/sync_mem_ctrl.sv
// Single-port synchronous memory with valid/ready requests, registered read response and clear sweep.
// Define SYNC_MEM_PARITY_EN to store an even-parity bit per word and report it on rsp_perr.
module sync_mem_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_perr
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_ptr;
    logic                  r_busy;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_perr;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_rd_perr;

    // A clear request always wins over a request presented in the same cycle.
    assign req_ready  = (r_state == ST_IDLE) && !clr_req;
    assign w_accept   = req_valid && req_ready;
    assign w_in_range = (32'(req_addr) < 32'(DEPTH));

    // The sweep and request writes share the single write port.
    assign w_we    = (r_state == ST_CLEAR) || (w_accept && req_write && w_in_range);
    assign w_waddr = (r_state == ST_CLEAR) ? r_clr_ptr : req_addr;
    assign w_wdata = (r_state == ST_CLEAR) ? '0 : req_wdata;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

`ifdef SYNC_MEM_PARITY_EN
    logic r_par [0:DEPTH-1];
    logic w_wpar;

    assign w_wpar = (r_state == ST_CLEAR) ? 1'b0 : ^req_wdata;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_par[w_waddr] <= w_wpar;
        end
    end

    assign w_rd_perr = (r_par[req_addr] != ^r_mem[req_addr]);
`else
    assign w_rd_perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_clr_ptr   <= '0;
            r_busy      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_perr  <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_clr_ptr <= '0;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + 1'b1;
                    end
                end
                default: begin
                    if (clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_busy    <= 1'b1;
                        r_clr_ptr <= '0;
                    end
                end
            endcase
            // Out-of-range reads still respond, with zero data and no parity error.
            if (w_accept && !req_write) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= w_in_range ? r_mem[req_addr] : '0;
                r_rsp_perr  <= w_in_range ? w_rd_perr : 1'b0;
            end
        end
    end

    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_perr  = r_rsp_perr;

endmodule

// File: tb/tb_sync_mem_ctrl.sv
// Self-checking bench for sync_mem_ctrl: random request traffic against an array model,
// clear/reset sweeps and an out-of-range instance with DEPTH=12.
module tb_sync_mem_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int D  = 16;
    localparam int D2 = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req_valid, req_write, clr_req;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready, busy, rsp_valid, rsp_perr;
    logic [DW-1:0] rsp_rdata;

    logic          req_valid2, req_write2, clr_req2;
    logic [AW-1:0] req_addr2;
    logic [DW-1:0] req_wdata2;
    logic          req_ready2, busy2, rsp_valid2, rsp_perr2;
    logic [DW-1:0] rsp_rdata2;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_mem [0:D-1];
    logic [DW-1:0] last_rdata;

    sync_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .clr_req(clr_req),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr)
    );

    sync_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D2)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
        .req_addr(req_addr2), .req_wdata(req_wdata2), .clr_req(clr_req2),
        .busy(busy2), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_perr(rsp_perr2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_write = 1'b0;
        clr_req   = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < D; i++) model_mem[i] = '0;
        last_rdata = '0;
    endtask

    task automatic test_reset();
        int cnt;
        rst_n = 1'b0;
        idle_req();
        req_addr = '0; req_wdata = '0;
        req_valid2 = 1'b0; req_write2 = 1'b0; clr_req2 = 1'b0;
        req_addr2 = '0; req_wdata2 = '0;
        cyc(); cyc();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 00", rsp_rdata); end
        checks++; if (rsp_perr !== 1'b0) begin errors++; $display("FAIL reset_rsp_perr got %b exp 0", rsp_perr); end
        rst_n = 1'b1;
        model_clear();
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            req_valid = 1'b1;
            req_write = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
            #1;
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sweep_ready cycle %0d got %b exp 0", cnt, req_ready); end
            cnt++;
            cyc();
        end
        idle_req();
        checks++; if (cnt != D) begin errors++; $display("FAIL reset_busy_len got %0d exp %0d", cnt, D); end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
        cyc();
        idle_req();
        last_rdata = model_mem[5];
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL read5_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp_rdata !== last_rdata) begin errors++; $display("FAIL read5_data got %h exp %h", rsp_rdata, last_rdata); end
        cyc();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read5_pulse got %b exp 0", rsp_valid); end
    endtask

    task automatic test_fill_readback();
        for (int i = 0; i < D; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(i); req_wdata = DW'(i * 3);
            cyc();
            model_mem[i] = DW'(i * 3);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL write_no_rsp addr %0d got %b exp 0", i, rsp_valid); end
        end
        req_write = 1'b0;
        for (int i = 0; i < D; i++) begin
            req_addr = AW'(i);
            cyc();
            last_rdata = model_mem[i];
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid addr %0d got %b exp 1", i, rsp_valid); end
            checks++; if (rsp_rdata !== last_rdata) begin errors++; $display("FAIL b2b_data addr %0d got %h exp %h", i, rsp_rdata, last_rdata); end
        end
        idle_req();
        cyc();
    endtask

    task automatic test_raw_random();
        int op;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
        cyc();
        model_mem[3] = 8'hA5;
        req_write = 1'b0;
        cyc();
        idle_req();
        last_rdata = model_mem[3];
        checks++; if (rsp_rdata !== 8'hA5 || rsp_valid !== 1'b1) begin errors++; $display("FAIL raw_data got %h/%b exp a5/1", rsp_rdata, rsp_valid); end
        checks++; if (rsp_perr !== 1'b0) begin errors++; $display("FAIL raw_perr got %b exp 0", rsp_perr); end
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 2));
            a  = AW'($urandom_range(0, D - 1));
            d  = DW'($urandom);
            req_valid = (op != 0);
            req_write = (op == 1);
            req_addr  = a;
            req_wdata = d;
            cyc();
            if (op == 2) last_rdata = model_mem[a];
            if (op == 1) model_mem[a] = d;
            checks++; if (rsp_valid !== (op == 2)) begin errors++; $display("FAIL rand_valid op %0d got %b exp %b", n, rsp_valid, (op == 2)); end
            checks++; if (rsp_rdata !== last_rdata) begin errors++; $display("FAIL rand_data op %0d addr %0d got %h exp %h", n, a, rsp_rdata, last_rdata); end
            if (op == 2) begin
                checks++; if (rsp_perr !== 1'b0) begin errors++; $display("FAIL rand_perr op %0d got %b exp 0", n, rsp_perr); end
            end
        end
        idle_req();
        cyc();
    endtask

    task automatic test_clear_collision();
        int cnt;
        logic [DW-1:0] d;
        d = DW'($urandom_range(1, 255));
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd9; req_wdata = d;
        cyc();
        model_mem[9] = d;
        req_write = 1'b0;
        cyc();
        last_rdata = model_mem[9];
        clr_req = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd2; req_wdata = 8'h77;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL clr_collide_ready got %b exp 0", req_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== last_rdata) begin errors++; $display("FAIL pre_clear_read got %b/%h exp 1/%h", rsp_valid, rsp_rdata, last_rdata); end
        cyc();
        idle_req();
        for (int i = 0; i < D; i++) model_mem[i] = '0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            clr_req   = (cnt == 5);
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom_range(1, 255));
            #1;
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL clr_sweep_ready cycle %0d got %b exp 0", cnt, req_ready); end
            cnt++;
            cyc();
        end
        idle_req();
        checks++; if (cnt != D) begin errors++; $display("FAIL clr_busy_len got %0d exp %0d", cnt, D); end
        req_valid = 1'b1;
        for (int i = 0; i < D; i++) begin
            req_addr = AW'(i);
            cyc();
            last_rdata = model_mem[i];
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== last_rdata) begin errors++; $display("FAIL clr_read addr %0d got %b/%h exp 1/%h", i, rsp_valid, rsp_rdata, last_rdata); end
        end
        idle_req();
        cyc();
    endtask

    task automatic test_reset_mid();
        int cnt;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_sweep_reset got busy %b valid %b exp 1/0", busy, rsp_valid); end
        cyc();
        rst_n = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin cnt++; cyc(); end
        checks++; if (cnt != D) begin errors++; $display("FAIL mid_sweep_busy_len got %0d exp %0d", cnt, D); end
        model_clear();
        a = AW'($urandom);
        d = DW'($urandom_range(1, 255));
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        cyc();
        model_mem[a] = d;
        req_write = 1'b0;
        cyc();
        idle_req();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== model_mem[a]) begin errors++; $display("FAIL pre_reset_read got %b/%h exp 1/%h", rsp_valid, rsp_rdata, model_mem[a]); end
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL inflight_reset_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL inflight_reset_rdata got %h exp 00", rsp_rdata); end
        cyc();
        rst_n = 1'b1;
        model_clear();
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin cnt++; cyc(); end
        checks++; if (cnt != D) begin errors++; $display("FAIL post_reset_busy_len got %0d exp %0d", cnt, D); end
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        cyc();
        idle_req();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== model_mem[a]) begin errors++; $display("FAIL post_reset_read got %b/%h exp 1/%h", rsp_valid, rsp_rdata, model_mem[a]); end
        cyc();
    endtask

    task automatic test_oob();
        logic [DW-1:0] d;
        d = DW'($urandom_range(1, 254));
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL d12_busy got %b exp 0", busy2); end
        req_valid2 = 1'b1; req_write2 = 1'b1;
        req_addr2 = 4'd11; req_wdata2 = d;    cyc();
        req_addr2 = 4'hF;  req_wdata2 = 8'hFF; cyc();
        req_addr2 = 4'd12; req_wdata2 = 8'hFF; cyc();
        req_write2 = 1'b0;
        req_addr2 = 4'd11; cyc();
        checks++; if (rsp_valid2 !== 1'b1 || rsp_rdata2 !== d) begin errors++; $display("FAIL d12_read11 got %b/%h exp 1/%h", rsp_valid2, rsp_rdata2, d); end
        req_addr2 = 4'hF; cyc();
        checks++; if (rsp_valid2 !== 1'b1 || rsp_rdata2 !== 8'h00) begin errors++; $display("FAIL d12_readF got %b/%h exp 1/00", rsp_valid2, rsp_rdata2); end
        checks++; if (rsp_perr2 !== 1'b0) begin errors++; $display("FAIL d12_readF_perr got %b exp 0", rsp_perr2); end
        req_addr2 = 4'd12; cyc();
        checks++; if (rsp_valid2 !== 1'b1 || rsp_rdata2 !== 8'h00) begin errors++; $display("FAIL d12_read12 got %b/%h exp 1/00", rsp_valid2, rsp_rdata2); end
        req_addr2 = 4'd11; cyc();
        checks++; if (rsp_valid2 !== 1'b1 || rsp_rdata2 !== d) begin errors++; $display("FAIL d12_read11_again got %b/%h exp 1/%h", rsp_valid2, rsp_rdata2, d); end
        req_valid2 = 1'b0;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_readback();
        test_raw_random();
        test_clear_collision();
        test_reset_mid();
        test_oob();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
